// File: rtl/dot_fp6_pkg.sv
// Shared widths and state encoding for the dot_fp6 sequencer.
package dot_fp6_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // sign + exponent + mantissa
  function automatic int bit_width(int exp_width, int man_width);
    return 1 + exp_width + man_width;
  endfunction

  // unsigned product of two element magnitudes (each (1<<exp_width)+man_width bits)
  function automatic int prd_width(int exp_width, int man_width);
    return 2 * ((1 << exp_width) + man_width);
  endfunction

  // signed dot product of k lanes
  function automatic int out_width(int exp_width, int man_width, int k);
    return 2 * ((1 << exp_width) + man_width + 2) + $clog2(k);
  endfunction

  // accumulator over max_blocks dot products
  function automatic int acc_width(int exp_width, int man_width, int k, int max_blocks);
    return out_width(exp_width, man_width, k) + $clog2(max_blocks);
  endfunction

endpackage

// File: rtl/dot_fp6_seq_dot.sv
// Combinational k-lane FP dot product. Each element is turned into an exact
// integer in units of the minimum subnormal, so the sum is exact and in units
// of (min subnormal)^2.
module dot_fp6
  import dot_fp6_pkg::*;
#(
  parameter int exp_width = 4,
  parameter int man_width = 3,
  parameter int k         = 32,
  localparam int BW = bit_width(exp_width, man_width),
  localparam int OW = out_width(exp_width, man_width, k)
) (
  input  logic [k-1:0][BW-1:0] vec_a,
  input  logic [k-1:0][BW-1:0] vec_b,
  output logic signed [OW-1:0] dot
);

  localparam int MW = prd_width(exp_width, man_width) / 2;

  logic [k-1:0][OW-1:0] prod;

  for (genvar i = 0; i < k; i++) begin : g_lane
    logic [exp_width-1:0] ea, eb;
    logic [man_width-1:0] fa, fb;
    logic [MW-1:0]        ma, mb;
    logic [2*MW-1:0]      pm;
    logic                 neg;

    assign ea  = vec_a[i][BW-2 -: exp_width];
    assign eb  = vec_b[i][BW-2 -: exp_width];
    assign fa  = vec_a[i][man_width-1:0];
    assign fb  = vec_b[i][man_width-1:0];
    // subnormal: bare mantissa; normal: hidden one, shifted by exponent-1
    assign ma  = (ea == '0) ? MW'(fa) : MW'({1'b1, fa}) << (ea - 1'b1);
    assign mb  = (eb == '0) ? MW'(fb) : MW'({1'b1, fb}) << (eb - 1'b1);
    assign pm  = (2*MW)'(ma) * (2*MW)'(mb);
    assign neg = vec_a[i][BW-1] ^ vec_b[i][BW-1];
    assign prod[i] = neg ? -OW'(pm) : OW'(pm);
  end

  // two's complement lane sum; OW has headroom for all k lanes
  always_comb begin
    dot = '0;
    for (int i = 0; i < k; i++) dot = dot + $signed(prod[i]);
  end

endmodule

// File: rtl/dot_fp6_seq.sv
// Job sequencer: accepts len operand blocks, registers each block's dot
// product, and sums them into a wide accumulator returned over valid/ready.
module dot_fp6_seq
  import dot_fp6_pkg::*;
#(
  parameter int exp_width  = 4,
  parameter int man_width  = 3,
  parameter int k          = 32,
  parameter int max_blocks = 16,
  localparam int BW = bit_width(exp_width, man_width),
  localparam int LW = $clog2(max_blocks + 1),
  localparam int OW = out_width(exp_width, man_width, k),
  localparam int AW = acc_width(exp_width, man_width, k, max_blocks)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [LW-1:0]        i_len,
  output logic                 o_busy,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [k-1:0][BW-1:0] i_vec_a,
  input  logic [k-1:0][BW-1:0] i_vec_b,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic signed [AW-1:0] o_acc
);

  state_t                state;
  logic [LW-1:0]         len, cnt;
  logic signed [AW-1:0]  acc;
  logic signed [OW-1:0]  p1, dot;
  logic                  p1_vld;
  logic                  accept;

  dot_fp6 #(
    .exp_width (exp_width),
    .man_width (man_width),
    .k         (k)
  ) u_dot (
    .vec_a (i_vec_a),
    .vec_b (i_vec_b),
    .dot   (dot)
  );

  // ready depends only on registered state, never on i_valid
  assign o_ready = (state == RUN) && (cnt < len);
  assign accept  = i_valid && o_ready;
  assign o_busy  = (state != IDLE);
  assign o_valid = (state == DONE);
  assign o_acc   = acc;

  // FSM, beat counter, p1 pipeline register and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      len    <= '0;
      cnt    <= '0;
      acc    <= '0;
      p1     <= '0;
      p1_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          p1_vld <= 1'b0;
          if (i_start) begin
            acc <= '0;
            cnt <= '0;
            if (i_len != '0) begin
              len   <= (i_len > LW'(max_blocks)) ? LW'(max_blocks) : i_len;
              state <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (accept) begin
            p1     <= dot;
            p1_vld <= 1'b1;
            cnt    <= cnt + 1'b1;
          end else begin
            p1_vld <= 1'b0;
          end
          if (p1_vld) begin
            acc <= acc + {{(AW-OW){p1[OW-1]}}, p1};
            // cnt==len with a pending p1 means this is the last block
            if (cnt == len) state <= DONE;
          end
        end
        DONE: begin
          p1_vld <= 1'b0;
          if (i_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_fp6_seq.sv
// Directed bench for dot_fp6_seq: table of whole jobs plus hand sequences
// for stalls, zero-length jobs and mid-job reset.
module tb_dot_fp6_seq;

  localparam int K  = 32;
  localparam int BW = 8;
  localparam int LW = 5;
  localparam int AW = 51;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_start;
  logic [LW-1:0]        i_len;
  logic                 o_busy;
  logic                 i_valid;
  logic                 o_ready;
  logic [K-1:0][BW-1:0] i_vec_a, i_vec_b;
  logic                 o_valid;
  logic                 i_ready;
  logic signed [AW-1:0] o_acc;

  dot_fp6_seq dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len), .o_busy(o_busy),
    .i_valid(i_valid), .o_ready(o_ready), .i_vec_a(i_vec_a), .i_vec_b(i_vec_b),
    .o_valid(o_valid), .i_ready(i_ready), .o_acc(o_acc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [K-1:0][BW-1:0] blk_a [16];
  logic [K-1:0][BW-1:0] blk_b [16];

  typedef struct {
    int          len;
    logic [7:0]  a0, b0, ar, br;
    longint      exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // element value in units of the minimum subnormal
  function automatic longint elem(input logic [7:0] x);
    longint mag;
    int e;
    e = int'(x[6:3]);
    if (e == 0) mag = longint'(x[2:0]);
    else        mag = (longint'(x[2:0]) + 8) * (64'sd1 <<< (e - 1));
    return x[7] ? -mag : mag;
  endfunction

  function automatic logic [K-1:0][BW-1:0] fill(input logic [7:0] v);
    logic [K-1:0][BW-1:0] r;
    for (int i = 0; i < K; i++) r[i] = v;
    return r;
  endfunction

  // drive a whole job from negedge to negedge and check handshake timing
  task automatic run_job(input int len_in, input int nblk, input longint exp,
                         input int vprob, input int stall, input bit pulse_start,
                         input bit hs_start, input string nm);
    int   beats;
    int   cyc;
    logic took;
    beats = 0;
    cyc   = 0;
    i_start = 1'b1;
    i_len   = LW'(len_in);
    @(negedge clk);
    i_start = 1'b0;
    chk({nm, ".busy"}, longint'(o_busy), 1);
    if (nblk == 0) begin
      chk({nm, ".valid_next"}, longint'(o_valid), 1);
      chk({nm, ".ready_low"}, longint'(o_ready), 0);
    end else begin
      while (beats < nblk && cyc < 2000) begin
        i_valid = ($urandom_range(99) < vprob);
        if (i_valid) begin
          i_vec_a = blk_a[beats];
          i_vec_b = blk_b[beats];
        end else begin
          for (int i = 0; i < K; i++) begin
            i_vec_a[i] = 8'($urandom());
            i_vec_b[i] = 8'($urandom());
          end
        end
        if (pulse_start && beats == 1) begin
          i_start = 1'b1;
          i_len   = LW'(1);
        end
        took = i_valid && o_ready;
        @(negedge clk);
        i_start = 1'b0;
        i_valid = 1'b0;
        cyc++;
        if (took) beats++;
      end
      if (cyc >= 2000) chk({nm, ".timeout"}, longint'(beats), longint'(nblk));
      chk({nm, ".ready_after_last"}, longint'(o_ready), 0);
      chk({nm, ".valid_early"}, longint'(o_valid), 0);
      @(negedge clk);
      chk({nm, ".valid"}, longint'(o_valid), 1);
    end
    chk({nm, ".acc"}, longint'(o_acc), exp);
    i_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({nm, ".stall_valid"}, longint'(o_valid), 1);
      chk({nm, ".stall_acc"}, longint'(o_acc), exp);
    end
    i_ready = 1'b1;
    i_start = hs_start;
    i_len   = LW'(1);
    @(negedge clk);
    i_ready = 1'b0;
    i_start = 1'b0;
    chk({nm, ".valid_gone"}, longint'(o_valid), 0);
    chk({nm, ".idle"}, longint'(o_busy), 0);
    chk({nm, ".acc_hold"}, longint'(o_acc), exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint exp;
    int     nb;

    tbl[0] = '{4,  8'h01, 8'h01, 8'h01, 8'h01, 64'sd128};
    tbl[1] = '{2,  8'h81, 8'h01, 8'h00, 8'h00, -64'sd32};
    tbl[2] = '{16, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 64'sd30923764531200};
    tbl[3] = '{1,  8'h08, 8'h08, 8'h08, 8'h08, 64'sd2048};
    tbl[4] = '{3,  8'h11, 8'h91, 8'h11, 8'h91, -64'sd31104};
    tbl[5] = '{20, 8'h01, 8'h01, 8'h01, 8'h01, 64'sd512};
    tbl[6] = '{1,  8'h7F, 8'h01, 8'h00, 8'h00, 64'sd7864320};
    tbl[7] = '{2,  8'h38, 8'hB8, 8'h01, 8'h01, -64'sd8388576};

    rst_n   = 1'b0;
    i_start = 1'b0;
    i_len   = '0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_vec_a = '0;
    i_vec_b = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy",  longint'(o_busy),  0);
    chk("rst.ready", longint'(o_ready), 0);
    chk("rst.valid", longint'(o_valid), 0);
    chk("rst.acc",   longint'(o_acc),   0);
    rst_n = 1'b1;
    @(negedge clk);

    // table of jobs at full throughput
    for (int t = 0; t < 8; t++) begin
      nb = (tbl[t].len > 16) ? 16 : tbl[t].len;
      for (int b = 0; b < 16; b++) begin
        blk_a[b] = fill((b == 0) ? tbl[t].a0 : tbl[t].ar);
        blk_b[b] = fill((b == 0) ? tbl[t].b0 : tbl[t].br);
      end
      run_job(tbl[t].len, nb, tbl[t].exp, 100, 0, 1'b0, 1'b0, $sformatf("tbl%0d", t));
    end

    // random data, 50% valid, result stall, start pulses mid-job and at handshake
    exp = 0;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < K; i++) begin
        blk_a[b][i] = 8'($urandom());
        blk_b[b][i] = 8'($urandom());
        exp += elem(blk_a[b][i]) * elem(blk_b[b][i]);
      end
    run_job(3, 3, exp, 50, 5, 1'b1, 1'b1, "rand");

    // zero-length job
    run_job(0, 0, 0, 100, 2, 1'b0, 1'b0, "len0");

    // reset after two of four beats
    for (int b = 0; b < 16; b++) begin
      blk_a[b] = fill(8'h01);
      blk_b[b] = fill(8'h01);
    end
    i_start = 1'b1;
    i_len   = LW'(4);
    @(negedge clk);
    i_start = 1'b0;
    i_vec_a = blk_a[0];
    i_vec_b = blk_b[0];
    i_valid = 1'b1;
    repeat (2) @(negedge clk);
    i_valid = 1'b0;
    chk("mid.acc_partial", longint'(o_acc), 32);
    rst_n = 1'b0;
    #1;
    chk("mid.busy",  longint'(o_busy),  0);
    chk("mid.ready", longint'(o_ready), 0);
    chk("mid.valid", longint'(o_valid), 0);
    chk("mid.acc",   longint'(o_acc),   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid.still_idle", longint'(o_valid), 0);
    run_job(1, 1, 32, 100, 0, 1'b0, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
